mips_instr_encoder_loader: RTL and testbench

// - Producer side of the main-decoder path: builds 32-bit MIPS instruction words from field-level requests and writes

---
 rtl/mips_pkg.sv | 28 ++
 rtl/mips_instr_encode.sv | 32 +++
 rtl/mips_instr_encoder_loader.sv | 139 +++++++++++++
 tb/tb_mips_instr_encoder_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode constants, request class codes and loader FSM states
package mips_pkg;

  // Primary opcodes, shared with the main decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Request class codes; 6 and 7 are illegal
  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_LW   = 3'd1;
  localparam logic [2:0] CLS_SW   = 3'd2;
  localparam logic [2:0] CLS_BEQ  = 3'd3;
  localparam logic [2:0] CLS_ADDI = 3'd4;
  localparam logic [2:0] CLS_J    = 3'd5;

  // Loader FSM states; ST_VERIFY is only reachable in the readback build
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_VERIFY = 2'd3
  } state_e;

endpackage

// File: rtl/mips_instr_encode.sv
// rtl/mips_instr_encode.sv - combinational field-to-word MIPS encoder with illegal-class flag
module mips_instr_encode
  import mips_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Pack fields per instruction format; fields a format does not use are ignored
  always_comb begin
    word_o    = 32'd0;
    illegal_o = 1'b0;
    case (cls_i)
      CLS_R:    word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
      CLS_LW:   word_o = {OP_LW,   rs_i, rt_i, imm_i};
      CLS_SW:   word_o = {OP_SW,   rs_i, rt_i, imm_i};
      CLS_BEQ:  word_o = {OP_BEQ,  rs_i, rt_i, imm_i};
      CLS_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      CLS_J:    word_o = {OP_J, target_i};
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder_loader.sv
// rtl/mips_instr_encoder_loader.sv - sequential instruction-memory loader; optional readback via MIPS_ENC_READBACK_EN
module mips_instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_class,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              err_illegal,
  output logic              err_verify
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);

  state_e             state_q;
  logic [2:0]         cls_q;
  logic [4:0]         rs_q, rt_q, rd_q, shamt_q;
  logic [5:0]         funct_q;
  logic [15:0]        imm_q;
  logic [25:0]        target_q;
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [ADDR_W:0]    cnt_q;
  logic [ADDR_W:0]    cnt_d;
  logic [31:0]        enc_word;
  logic               enc_illegal;
  logic               xfer;

  mips_instr_encode u_encode (
    .cls_i     (cls_q),
    .rs_i      (rs_q),
    .rt_i      (rt_q),
    .rd_i      (rd_q),
    .shamt_i   (shamt_q),
    .funct_i   (funct_q),
    .imm_i     (imm_q),
    .target_i  (target_q),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // The write pointer doubles as the written-word count, so one counter serves both
  assign cnt_d     = cnt_q + ONE_C;
  assign full      = (cnt_q == DEPTH_C);
  assign req_ready = (state_q == ST_IDLE) && !full;
  assign xfer      = req_valid && req_ready;
  assign wr_count  = cnt_q;
  assign imem_wdata = wdata_q;
  // A clear landing in the WRITE cycle must suppress the strobe already registered
  assign imem_we     = we_q && !clear && !rst;
  assign err_illegal = (state_q == ST_ENCODE) && enc_illegal && !clear && !rst;

`ifdef MIPS_ENC_READBACK_EN
  logic verr_q;
  assign err_verify = verr_q;
  // During VERIFY the pointer has already advanced, so look back at the word just written
  assign imem_addr  = (state_q == ST_VERIFY) ? (cnt_q[ADDR_W-1:0] - ONE_C[ADDR_W-1:0])
                                             : cnt_q[ADDR_W-1:0];
`else
  logic unused_rdata;
  assign unused_rdata = ^imem_rdata;
  assign err_verify   = 1'b0;
  assign imem_addr    = cnt_q[ADDR_W-1:0];
`endif

  // Loader FSM: capture request, encode, strobe the write, optionally verify
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
`ifdef MIPS_ENC_READBACK_EN
      verr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            cls_q    <= req_class;
            rs_q     <= req_rs;
            rt_q     <= req_rt;
            rd_q     <= req_rd;
            shamt_q  <= req_shamt;
            funct_q  <= req_funct;
            imm_q    <= req_imm;
            target_q <= req_target;
            state_q  <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          if (enc_illegal) begin
            state_q <= ST_IDLE;
          end else begin
            wdata_q <= enc_word;
            we_q    <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          we_q    <= 1'b0;
          cnt_q   <= cnt_d;
`ifdef MIPS_ENC_READBACK_EN
          state_q <= ST_VERIFY;
`else
          state_q <= ST_IDLE;
`endif
        end
`ifdef MIPS_ENC_READBACK_EN
        ST_VERIFY: begin
          if (imem_rdata != wdata_q) verr_q <= 1'b1;
          state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder_loader.sv
// tb/tb_mips_instr_encoder_loader.sv - self-checking bench for mips_instr_encoder_loader (honours MIPS_ENC_READBACK_EN)
module tb_mips_instr_encoder_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
`ifdef MIPS_ENC_READBACK_EN
  localparam int PERIOD = 4;
`else
  localparam int PERIOD = 3;
`endif

  logic              clk = 1'b0;
  logic              rst, clear, req_valid, req_ready;
  logic [2:0]        req_class;
  logic [4:0]        req_rs, req_rt, req_rd, req_shamt;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata, imem_rdata;
  logic [ADDR_W:0]   wr_count;
  logic              full, err_illegal, err_verify;

  always #5 clk = ~clk;

  mips_instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .wr_count(wr_count), .full(full), .err_illegal(err_illegal), .err_verify(err_verify)
  );

  // Instruction memory model with combinational read and optional bit-0 corruption
  logic [31:0] mem [0:31];
  logic        corrupt = 1'b0;
  assign imem_rdata = mem[imem_addr] ^ {31'd0, corrupt};
  always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

  // Write monitor
  typedef struct { int addr; logic [31:0] data; int at; } wr_t;
  wr_t wr_log[$];
  wr_t exp_q[$];
  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (imem_we) wr_log.push_back('{int'(imem_addr), imem_wdata, cyc});

  typedef struct { int cls; int rs; int rt; int rd; int sh; int fn; int imm; int tgt; } req_t;
  typedef struct { req_t r; logic [31:0] exp; bit ill; } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference encoder: arithmetic placement of fields by format
  function automatic logic [31:0] ref_word(input req_t r, output bit ill);
    int     opc [6] = '{0, 35, 43, 4, 8, 2};
    longint w;
    ill = 0;
    w   = 0;
    if (r.cls > 5) ill = 1;
    else if (r.cls == 0)
      w = longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.rd) * 2048
          + longint'(r.sh) * 64 + longint'(r.fn);
    else if (r.cls == 5)
      w = longint'(opc[5]) * 67108864 + longint'(r.tgt);
    else
      w = longint'(opc[r.cls]) * 67108864 + longint'(r.rs) * 2097152
          + longint'(r.rt) * 65536 + longint'(r.imm);
    return w[31:0];
  endfunction

  task automatic send(input req_t r, input int budget, output bit ok);
    @(negedge clk);
    req_class  = r.cls[2:0];
    req_rs     = r.rs[4:0];
    req_rt     = r.rt[4:0];
    req_rd     = r.rd[4:0];
    req_shamt  = r.sh[4:0];
    req_funct  = r.fn[5:0];
    req_imm    = r.imm[15:0];
    req_target = r.tgt[25:0];
    req_valid  = 1'b1;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic compare_log(input string name);
    chk({name, "_count"}, wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      chk({name, "_addr"}, wr_log[i].addr, exp_q[i].addr);
      chk({name, "_data"}, wr_log[i].data, exp_q[i].data);
    end
    wr_log.delete();
    exp_q.delete();
  endtask

  vec_t vecs [8];
  req_t r;
  bit   ok, ill;
  int   xfers, mcount;
  logic [31:0] w;

  initial begin
    vecs[0] = '{'{0, 1, 2, 3, 0, 32, 16'hABCD, 26'h1234567}, 32'h00221820, 0};
    vecs[1] = '{'{1, 0, 8, 31, 7, 63, 16'h0004, 0}, 32'h8C080004, 0};
    vecs[2] = '{'{2, 29, 31, 0, 0, 0, 16'hFFFC, 0}, 32'hAFBFFFFC, 0};
    vecs[3] = '{'{3, 4, 5, 0, 0, 0, 16'hFFFF, 0}, 32'h1085FFFF, 0};
    vecs[4] = '{'{4, 0, 2, 0, 0, 0, 16'h0001, 0}, 32'h20020001, 0};
    vecs[5] = '{'{5, 31, 31, 31, 31, 63, 16'hFFFF, 26'h3FFFFFF}, 32'h0BFFFFFF, 0};
    vecs[6] = '{'{0, 0, 5, 4, 31, 0, 0, 0}, 32'h000527C0, 0};
    vecs[7] = '{'{6, 1, 2, 3, 4, 5, 6, 7}, 32'h0, 1};

    rst = 1'b1; clear = 1'b0; req_valid = 1'b0;
    req_class = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0;
    req_funct = '0; req_imm = '0; req_target = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_full", full, 0);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_verify", err_verify, 0);

    // R-type latency: write strobe in cycle T+2, ready again at T+3 (T+4 with readback)
    send('{0, 1, 2, 3, 0, 32, 0, 0}, 4, ok);
    chk("r_xfer", ok, 1);
    @(negedge clk);
    chk("r_we_t1", imem_we, 0);
    @(negedge clk);
    chk("r_we_t2", imem_we, 1);
    chk("r_addr", imem_addr, 0);
    chk("r_wdata", imem_wdata, 32'h00221820);
    @(negedge clk);
    chk("r_count", wr_count, 1);
    chk("r_we_t3", imem_we, 0);
`ifdef MIPS_ENC_READBACK_EN
    chk("r_ready_t3", req_ready, 0);
    @(negedge clk);
`endif
    chk("r_ready", req_ready, 1);

    // LW then J back to back
    clear_pulse();
    wr_log.delete();
    send('{1, 0, 8, 0, 0, 0, 16'h0004, 0}, 4, ok);
    send('{5, 0, 0, 0, 0, 0, 0, 26'h0000010}, 8, ok);
    chk("lwj_xfer2", ok, 1);
    repeat (5) @(negedge clk);
    exp_q.push_back('{0, 32'h8C080004, 0});
    exp_q.push_back('{1, 32'h08000010, 0});
    if (wr_log.size() == 2) chk("lwj_spacing", wr_log[1].at - wr_log[0].at, PERIOD);
    else chk("lwj_spacing_count", wr_log.size(), 2);
    compare_log("lwj");

    // Illegal class 7
    clear_pulse();
    wr_log.delete();
    send('{7, 1, 2, 3, 4, 5, 6, 7}, 4, ok);
    @(negedge clk);
    chk("ill_pulse", err_illegal, 1);
    chk("ill_we", imem_we, 0);
    @(negedge clk);
    chk("ill_pulse_end", err_illegal, 0);
    chk("ill_ready", req_ready, 1);
    chk("ill_count", wr_count, 0);
    chk("ill_writes", wr_log.size(), 0);

    // Fill to DEPTH with five ADDI requests
    clear_pulse();
    wr_log.delete();
    xfers = 0;
    for (int i = 0; i < 5; i++) begin
      send('{4, i, i + 1, 0, 0, 0, 100 + i, 0}, 8, ok);
      if (ok) xfers++;
    end
    repeat (2) @(negedge clk);
    chk("full_xfers", xfers, DEPTH);
    chk("full_writes", wr_log.size(), DEPTH);
    chk("full_count", wr_count, DEPTH);
    chk("full_flag", full, 1);
    chk("full_ready", req_ready, 0);
    chk("full_addr", imem_addr, DEPTH);
    clear_pulse();
    @(negedge clk);
    chk("full_clr_count", wr_count, 0);
    chk("full_clr_flag", full, 0);
    chk("full_clr_ready", req_ready, 1);
    chk("full_clr_addr", imem_addr, 0);

    // clear during ENCODE
    wr_log.delete();
    send('{0, 1, 2, 3, 0, 32, 0, 0}, 4, ok);
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_enc_we", imem_we, 0);
    chk("clr_enc_ready", req_ready, 1);
    chk("clr_enc_addr", imem_addr, 0);
    repeat (3) @(negedge clk);
    chk("clr_enc_writes", wr_log.size(), 0);
    chk("clr_enc_count", wr_count, 0);

    // clear during WRITE
    send('{4, 1, 1, 0, 0, 0, 5, 0}, 4, ok);
    @(negedge clk);
    @(posedge clk); #1 clear = 1'b1;
    @(negedge clk);
    chk("clr_wr_we", imem_we, 0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_wr_count", wr_count, 0);
    chk("clr_wr_writes", wr_log.size(), 0);

    // Table of single-request vectors, each from a cleared loader
    for (int k = 0; k < 8; k++) begin
      clear_pulse();
      send(vecs[k].r, 4, ok);
      @(negedge clk);
      chk($sformatf("vec%0d_illegal", k), err_illegal, vecs[k].ill);
      @(negedge clk);
      chk($sformatf("vec%0d_we", k), imem_we, !vecs[k].ill);
      if (!vecs[k].ill) begin
        chk($sformatf("vec%0d_addr", k), imem_addr, 0);
        chk($sformatf("vec%0d_wdata", k), imem_wdata, vecs[k].exp);
      end
    end

    // Randomized requests against the reference encoder
    repeat (3) @(negedge clk);
    clear_pulse();
    wr_log.delete();
    exp_q.delete();
    mcount = 0;
    for (int n = 0; n < 60; n++) begin
      if (mcount == DEPTH) begin
        repeat (5) @(negedge clk);
        compare_log("rand");
        clear_pulse();
        mcount = 0;
      end
      r = '{$urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
            $urandom_range(0, 65535), $urandom_range(0, 67108863)};
      w = ref_word(r, ill);
      send(r, 10, ok);
      chk("rand_xfer", ok, 1);
      if (!ill) begin
        exp_q.push_back('{mcount, w, 0});
        mcount++;
      end
    end
    repeat (5) @(negedge clk);
    compare_log("rand");
    chk("rand_count", wr_count, mcount);

`ifdef MIPS_ENC_READBACK_EN
    // Corrupted readback sets a sticky error that only clear removes
    clear_pulse();
    corrupt = 1'b1;
    send('{4, 0, 2, 0, 0, 0, 1, 0}, 4, ok);
    repeat (4) @(negedge clk);
    chk("rb_err_set", err_verify, 1);
    corrupt = 1'b0;
    send('{4, 0, 3, 0, 0, 0, 2, 0}, 8, ok);
    repeat (4) @(negedge clk);
    chk("rb_err_sticky", err_verify, 1);
    clear_pulse();
    @(negedge clk);
    chk("rb_err_clear", err_verify, 0);
    send('{4, 0, 3, 0, 0, 0, 2, 0}, 8, ok);
    repeat (4) @(negedge clk);
    chk("rb_clean", err_verify, 0);
`else
    chk("no_rb_err", err_verify, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
